// File: rtl/brl_result_stage.sv
// Result/flag stage behind the barrel shifter: 2-entry skid FIFO feeding register-file
// write-back, plus the architectural Z/N/C flag register updated as shift results retire.
module brl_result_stage #(
  parameter int DW = 32,
  parameter int RW = 5
) (
  input  logic          clk,
  input  logic          resetl,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] brlq,
  input  logic          brl_carry,
  input  logic [RW-1:0] in_dst,
  input  logic          in_flagupd,
  input  logic          flush,
  output logic          wb_valid,
  input  logic          wb_ready,
  output logic [DW-1:0] wb_data,
  output logic [RW-1:0] wb_dst,
  output logic          flag_z,
  output logic          flag_n,
  output logic          flag_c
);

  logic [DW-1:0] r_data [2];
  logic [RW-1:0] r_dst  [2];
  logic          r_c    [2];
  logic          r_upd  [2];

  logic          r_wptr;
  logic          r_rptr;
  logic [1:0]    r_occ;
  logic          r_in_ready;
  logic [DW-1:0] r_last_data;
  logic [RW-1:0] r_last_dst;
  logic          r_flag_z;
  logic          r_flag_n;
  logic          r_flag_c;

  logic          w_push;
  logic          w_pop;
  logic          w_retire;
  logic [1:0]    w_occ_next;
  logic [DW-1:0] w_head_data;
  logic [RW-1:0] w_head_dst;

  assign w_push      = in_valid & r_in_ready;
  assign w_pop       = wb_valid & wb_ready;
  // A pop that coincides with flush is cancelled: no flag update, no last-value capture.
  assign w_retire    = w_pop & ~flush;
  assign w_head_data = r_data[r_rptr];
  assign w_head_dst  = r_dst[r_rptr];

  always_comb begin
    w_occ_next = r_occ;
    if (flush) begin
      w_occ_next = 2'd0;
    end else begin
      case ({w_push, w_pop})
        2'b10:   w_occ_next = r_occ + 2'd1;
        2'b01:   w_occ_next = r_occ - 2'd1;
        default: w_occ_next = r_occ;
      endcase
    end
  end

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_entry
      always_ff @(posedge clk or negedge resetl) begin
        if (!resetl) begin
          r_data[gi] <= '0;
          r_dst[gi]  <= '0;
          r_c[gi]    <= 1'b0;
          r_upd[gi]  <= 1'b0;
        end else if (w_push && !flush && (r_wptr == 1'(gi))) begin
          r_data[gi] <= brlq;
          r_dst[gi]  <= in_dst;
          r_c[gi]    <= brl_carry;
          r_upd[gi]  <= in_flagupd;
        end
      end
    end
  endgenerate

  always_ff @(posedge clk or negedge resetl) begin
    if (!resetl) begin
      r_wptr     <= 1'b0;
      r_rptr     <= 1'b0;
      r_occ      <= 2'd0;
      r_in_ready <= 1'b1;
    end else begin
      r_occ      <= w_occ_next;
      // Registered ready, so wb_ready never reaches in_ready combinationally.
      r_in_ready <= (w_occ_next != 2'd2);
      if (flush) begin
        r_wptr <= 1'b0;
        r_rptr <= 1'b0;
      end else begin
        if (w_push) r_wptr <= ~r_wptr;
        if (w_pop)  r_rptr <= ~r_rptr;
      end
    end
  end

  always_ff @(posedge clk or negedge resetl) begin
    if (!resetl) begin
      r_last_data <= '0;
      r_last_dst  <= '0;
      r_flag_z    <= 1'b0;
      r_flag_n    <= 1'b0;
      r_flag_c    <= 1'b0;
    end else if (w_retire) begin
      r_last_data <= w_head_data;
      r_last_dst  <= w_head_dst;
      if (r_upd[r_rptr]) begin
        r_flag_z <= (w_head_data == '0);
        r_flag_n <= w_head_data[DW-1];
        r_flag_c <= r_c[r_rptr];
      end
    end
  end

  assign in_ready = r_in_ready;
  assign wb_valid = (r_occ != 2'd0);
  assign wb_data  = wb_valid ? w_head_data : r_last_data;
  assign wb_dst   = wb_valid ? w_head_dst  : r_last_dst;
  assign flag_z   = r_flag_z;
  assign flag_n   = r_flag_n;
  assign flag_c   = r_flag_c;

endmodule

// File: tb/tb_brl_result_stage.sv
// Bench for brl_result_stage: directed scenarios then random traffic, all checked
// against a queue-based model of the write-back FIFO and flag register.
module tb_brl_result_stage;
  localparam int DW = 32;
  localparam int RW = 5;

  logic          clk = 1'b0;
  logic          resetl;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] brlq;
  logic          brl_carry;
  logic [RW-1:0] in_dst;
  logic          in_flagupd;
  logic          flush;
  logic          wb_valid;
  logic          wb_ready;
  logic [DW-1:0] wb_data;
  logic [RW-1:0] wb_dst;
  logic          flag_z, flag_n, flag_c;

  brl_result_stage #(.DW(DW), .RW(RW)) dut (
    .clk(clk), .resetl(resetl), .in_valid(in_valid), .in_ready(in_ready),
    .brlq(brlq), .brl_carry(brl_carry), .in_dst(in_dst), .in_flagupd(in_flagupd),
    .flush(flush), .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_data(wb_data),
    .wb_dst(wb_dst), .flag_z(flag_z), .flag_n(flag_n), .flag_c(flag_c)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [DW-1:0] data;
    logic [RW-1:0] dst;
    logic          c;
    logic          upd;
  } entry_t;

  entry_t        m_q[$];
  logic [DW-1:0] m_last_data;
  logic [RW-1:0] m_last_dst;
  logic [2:0]    m_flags;   // {z,n,c}
  int            n_cmp;
  int            n_fail;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    m_last_data = '0;
    m_last_dst  = '0;
    m_flags     = 3'b000;
  endtask

  task automatic check_all(input string tag);
    logic [DW-1:0] exp_data;
    logic [RW-1:0] exp_dst;
    exp_data = (m_q.size() > 0) ? m_q[0].data : m_last_data;
    exp_dst  = (m_q.size() > 0) ? m_q[0].dst  : m_last_dst;
    chk({tag, ".in_ready"}, 64'(in_ready), 64'(m_q.size() < 2));
    chk({tag, ".wb_valid"}, 64'(wb_valid), 64'(m_q.size() > 0));
    chk({tag, ".wb_data"},  64'(wb_data),  64'(exp_data));
    chk({tag, ".wb_dst"},   64'(wb_dst),   64'(exp_dst));
    chk({tag, ".flags"},    64'({flag_z, flag_n, flag_c}), 64'(m_flags));
  endtask

  // One clock: drive inputs just after a falling edge, update the model at the rising
  // edge, check everything at the next falling edge.
  task automatic cycle(input string tag, input logic iv, input logic [DW-1:0] d,
                       input logic c, input logic [RW-1:0] dst, input logic upd,
                       input logic wr, input logic fl);
    logic   push, pop;
    entry_t e;
    in_valid = iv; brlq = d; brl_carry = c; in_dst = dst; in_flagupd = upd;
    wb_ready = wr; flush = fl;
    push = iv && (m_q.size() < 2);
    pop  = wr && (m_q.size() > 0);
    @(posedge clk);
    if (fl) begin
      m_q.delete();
    end else begin
      if (pop) begin
        e = m_q.pop_front();
        m_last_data = e.data;
        m_last_dst  = e.dst;
        if (e.upd) m_flags = {(e.data == '0), e.data[DW-1], e.c};
      end
      if (push) m_q.push_back('{data: d, dst: dst, c: c, upd: upd});
    end
    @(negedge clk);
    check_all(tag);
  endtask

  task automatic idle(input string tag, input logic wr);
    cycle(tag, 1'b0, '0, 1'b0, '0, 1'b0, wr, 1'b0);
  endtask

  initial begin
    n_cmp = 0; n_fail = 0;
    resetl = 1'b0; in_valid = 1'b0; brlq = '0; brl_carry = 1'b0; in_dst = '0;
    in_flagupd = 1'b0; flush = 1'b0; wb_ready = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    chk("rst.in_ready", 64'(in_ready), 64'(1));
    chk("rst.wb_valid", 64'(wb_valid), 64'(0));
    chk("rst.flags", 64'({flag_z, flag_n, flag_c}), 64'(0));
    resetl = 1'b1;
    for (int i = 0; i < 5; i++) idle("idle", 1'b0);

    // Single push with flag update, immediate write-back
    cycle("t2.push", 1'b1, 32'h8000_0000, 1'b1, 5'd3, 1'b1, 1'b1, 1'b0);
    chk("t2.wb_data", 64'(wb_data), 64'(32'h8000_0000));
    idle("t2.pop", 1'b1);
    chk("t2.flags", 64'({flag_z, flag_n, flag_c}), 64'(3'b011));

    // Fill, overfill attempt, then drain
    cycle("t3.push1", 1'b1, 32'h0, 1'b0, 5'd1, 1'b1, 1'b0, 1'b0);
    cycle("t3.push2", 1'b1, 32'h1234, 1'b0, 5'd2, 1'b1, 1'b0, 1'b0);
    chk("t3.full", 64'(in_ready), 64'(0));
    cycle("t3.push3", 1'b1, 32'hdead, 1'b1, 5'd9, 1'b1, 1'b0, 1'b0);
    idle("t3.pop1", 1'b1);
    chk("t3.z1", 64'(flag_z), 64'(1));
    idle("t3.pop2", 1'b1);
    chk("t3.z2", 64'(flag_z), 64'(0));
    chk("t3.ready", 64'(in_ready), 64'(1));

    // Steady push+pop at occupancy 1
    cycle("t4.prime", 1'b1, 32'h100, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0);
    for (int i = 1; i <= 10; i++)
      cycle("t4.pp", 1'b1, 32'h100 + i, 1'(i & 1), 5'(i), 1'b1, 1'b1, 1'b0);
    idle("t4.drain", 1'b1);

    // Flush beats push and pop
    cycle("t5.fill1", 1'b1, 32'h0, 1'b1, 5'd4, 1'b1, 1'b0, 1'b0);
    cycle("t5.fill2", 1'b1, 32'h0, 1'b0, 5'd5, 1'b1, 1'b0, 1'b0);
    cycle("t5.flush", 1'b1, 32'h7, 1'b0, 5'd6, 1'b1, 1'b1, 1'b1);
    chk("t5.wb_valid", 64'(wb_valid), 64'(0));

    // flagupd=0 keeps flags; then async reset with a pending result
    cycle("t6.zset", 1'b1, 32'h0, 1'b1, 5'd7, 1'b1, 1'b1, 1'b0);
    idle("t6.zpop", 1'b1);
    cycle("t6.noupd", 1'b1, 32'h8000_0001, 1'b0, 5'd8, 1'b0, 1'b0, 1'b0);
    idle("t6.noupdpop", 1'b1);
    chk("t6.zkeep", 64'(flag_z), 64'(1));
    cycle("t6.pend", 1'b1, 32'h55, 1'b1, 5'd9, 1'b1, 1'b0, 1'b0);
    resetl = 1'b0;
    #1;
    model_reset();
    chk("t6.rst.wb_valid", 64'(wb_valid), 64'(0));
    chk("t6.rst.flags", 64'({flag_z, flag_n, flag_c}), 64'(0));
    chk("t6.rst.in_ready", 64'(in_ready), 64'(1));
    @(negedge clk);
    resetl = 1'b1;
    idle("t6.after", 1'b0);

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      logic [DW-1:0] d;
      d = ($urandom_range(0, 3) == 0) ? '0 : DW'($urandom);
      cycle("rnd", 1'($urandom_range(0, 3) != 0), d, 1'($urandom), 5'($urandom),
            1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 2) != 0),
            1'($urandom_range(0, 19) == 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
